// File: rtl/output_port_arbiter.sv
// Switch allocator for one output port of the router crossbar.
// Picks one of the input ports round-robin, holds that grant from the head
// flit to the tail flit, and only lets a flit cross when the downstream
// buffer has a free slot. It also counts the free downstream slots.
//
// Handshake: input i offers a flit with req[i]. The flit crosses in any
// cycle where flit_valid_out=1. In that cycle grant_ack[i]=1 pops it from
// input i. A granted input may drop req[i] for a while (a bubble). The grant
// is then held and nothing crosses. credit_in is a one-cycle pulse that
// returns one downstream slot.
module output_port_arbiter #(
    parameter int P_NUM_IN       = 5,
    parameter int P_BUFFER_DEPTH = 4,
    parameter int P_CREDIT_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [P_NUM_IN-1:0]       req,
    input  logic [P_NUM_IN-1:0]       tail,
    input  logic                      credit_in,
    output logic [P_NUM_IN-1:0]       select,
    output logic                      flit_valid_out,
    output logic [P_NUM_IN-1:0]       grant_ack,
    output logic [P_CREDIT_WIDTH-1:0] credit_count,
    output logic                      credit_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [P_CREDIT_WIDTH-1:0] CREDIT_FULL = P_CREDIT_WIDTH'(P_BUFFER_DEPTH);
    localparam logic [P_CREDIT_WIDTH-1:0] CREDIT_ONE  = P_CREDIT_WIDTH'(1);
    localparam logic [2:0]                LAST_PORT   = 3'(P_NUM_IN - 1);

    state_t              state;
    state_t              state_next;
    logic [P_NUM_IN-1:0] select_next;
    logic [2:0]          grant_idx;
    logic [2:0]          grant_idx_next;
    logic [2:0]          rr_ptr;
    logic [2:0]          rr_ptr_next;
    logic                xfer;

    logic [2:0]          win_idx;
    logic                win_found;
    logic [3:0]          scan_sum;
    logic [2:0]          scan_idx;

    // Round-robin scan: the first requester after the last granted port, with wrap-around.
    always_comb begin
        win_idx   = 3'd0;
        win_found = 1'b0;
        scan_sum  = 4'd0;
        scan_idx  = 3'd0;
        for (int k = 1; k <= P_NUM_IN; k++) begin
            scan_sum = {1'b0, rr_ptr} + 4'(k);
            scan_idx = (scan_sum >= 4'(P_NUM_IN)) ? 3'(scan_sum - 4'(P_NUM_IN)) : scan_sum[2:0];
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // State register: grant state, registered select, granted index and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            select    <= '0;
            grant_idx <= 3'd0;
            rr_ptr    <= LAST_PORT;
        end else begin
            state     <= state_next;
            select    <= select_next;
            grant_idx <= grant_idx_next;
            rr_ptr    <= rr_ptr_next;
        end
    end

    // Next state: grant the winner from IDLE, release after the tail flit crosses.
    always_comb begin
        state_next     = state;
        select_next    = select;
        grant_idx_next = grant_idx;
        rr_ptr_next    = rr_ptr;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next     = LOCKED;
                    select_next    = P_NUM_IN'(1) << win_idx;
                    grant_idx_next = win_idx;
                end
            end
            LOCKED: begin
                if (xfer && tail[grant_idx]) begin
                    state_next  = IDLE;
                    select_next = '0;
                    rr_ptr_next = grant_idx;
                end
            end
            default: begin
                state_next  = IDLE;
                select_next = '0;
            end
        endcase
    end

    // Outputs: a flit crosses only while locked, with the granted input offering and a credit available.
    always_comb begin
        xfer           = (state == LOCKED) && req[grant_idx] && (credit_count != '0) && !reset;
        flit_valid_out = xfer;
        grant_ack      = select & {P_NUM_IN{xfer}};
    end

    // Credit counter: +1 on credit_in, -1 on a transfer. An overflowing credit_in sets the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_count <= CREDIT_FULL;
            credit_err   <= 1'b0;
        end else if (credit_in && !xfer) begin
            if (credit_count == CREDIT_FULL) begin
                credit_err <= 1'b1;
            end else begin
                credit_count <= credit_count + CREDIT_ONE;
            end
        end else if (!credit_in && xfer) begin
            credit_count <= credit_count - CREDIT_ONE;
        end
    end

endmodule
